synthesijer_fcomp64_issue: RTL and testbench
============================================

Name: synthesijer_fcomp64_issue

Overview:
- Upstream issue/capture stage for the 64-bit float-compare wrapper (a/b/opcode/nd in; result/valid out).
- Accepts a single compare request from the Synthesijer-generated method FSM.
- Translates the HLS comparison code into the compare-core operation byte, drives a one-cycle nd pulse, and waits for valid.
- Returns a registered result with a done pulse and a busy flag, so the generated FSM never depends on core latency.

Parameters:
- TIMEOUT_CYCLES, 64, cycles to wait in WAIT before aborting (used only with the optional feature); legal range 2..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- req  in  1  request strobe; sampled only when busy=0
- a  in  64  operand A, IEEE-754 double
- b  in  64  operand B, IEEE-754 double
- op  in  3  0=LT 1=LEQ 2=GT 3=GEQ 4=EQ 5=NEQ 6/7=illegal
- busy  out  1  high from the cycle after an accepted req until the cycle after done
- done  out  1  one-cycle completion pulse
- result  out  1  comparison outcome, held until the next done
- error  out  1  held high with done when the op was illegal or the request timed out
- cmp_a  out  64  to compare core a
- cmp_b  out  64  to compare core b
- cmp_opcode  out  8  to compare core opcode
- cmp_nd  out  1  to compare core nd
- cmp_result  in  1  from compare core result
- cmp_valid  in  1  from compare core valid

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high, named reset.
- Reset values: busy=0, done=0, result=0, error=0, cmp_nd=0, cmp_a=0, cmp_b=0, cmp_opcode=0, state=IDLE.
- Reset mid-operation returns to IDLE next edge with no done. A cmp_valid arriving later for the aborted request is discarded.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: on req=1, register a, b, op and go to ISSUE; busy=1 next cycle.
  - If op is 6 or 7, go directly to DONE with result=0 and error=1. No nd is issued.
- Opcode map:
  - LT→0x0C, LEQ→0x1C, GT→0x24, GEQ→0x34, EQ→0x14, NEQ→0x2C.
  - Bits 7:6 are zero.
  - cmp_a, cmp_b and cmp_opcode hold their registered values from ISSUE through WAIT.
- ISSUE: cmp_nd=1 for exactly this one cycle, then go to WAIT.
- WAIT:
  - On cmp_valid=1, capture cmp_result into result, set error=0, go to DONE.
  - cmp_valid coincident with the ISSUE cycle is impossible by core latency (≥1 cycle) and is ignored.
- DONE: done=1 for one cycle, busy drops to 0 the following cycle, return to IDLE.
- req while busy=1 is ignored; no queueing. A req asserted in the DONE cycle is also ignored.
- cmp_valid while in IDLE, ISSUE or DONE is ignored. result is unchanged.
- Minimum request-to-done latency: core latency + 3 cycles (accept, ISSUE, WAIT capture, DONE).
- NaN operands need no special handling. The core answers false for ordered compares and true for NEQ, and result passes that through unchanged.

Optional Feature:
- Macro: SYNTHESIJER_FCOMP64_ISSUE_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without cmp_valid, go to DONE with result=0 and error=1.
  - A late cmp_valid after the timeout is ignored.
  - cmp_valid in the same cycle the counter reaches the limit wins: normal result, error=0.
- Undefined: no counter; WAIT waits indefinitely; error only signals illegal op.

Test Plan:
- Basic LT: a=1.0 (0x3FF0000000000000), b=2.0 (0x4000000000000000), op=0.
  - Model core: latency 4, responds 1.
  - Expect cmp_opcode=0x0C, a single cmp_nd pulse, done at 7 cycles after req, result=1, error=0.
- Opcode map: each op 0..5 in turn. Expect cmp_opcode 0x0C, 0x1C, 0x24, 0x34, 0x14, 0x2C; result equals the model output each time.
- Illegal op=7:
  - Expect cmp_nd never asserted; done 2 cycles after req with result=0, error=1.
  - A second req during busy is ignored; exactly one done is seen.
- Spurious valid:
  - Pulse cmp_valid=1 with cmp_result=1 while IDLE → result stays 0.
  - Assert reset during WAIT, then cmp_valid → no done, state IDLE, busy=0.
- Timeout (macro defined, TIMEOUT_CYCLES=8): core never responds.
  - Expect done 8 WAIT cycles after entering WAIT with result=0, error=1.
  - A subsequent late cmp_valid produces no done.
- Back-to-back: assert req again in the cycle after busy falls. Expect it accepted, a second cmp_nd pulse, and correct second result.

Source files
------------

// File: rtl/synthesijer_fcomp64_issue.sv
// -----------------------------------------------------------------------------
// synthesijer_fcomp64_issue
//
// Issue/capture stage in front of the 64-bit floating-point compare core.
// Takes one compare request from the generated method FSM and translates the
// HLS comparison code into the core's operation byte. It then fires a single
// nd pulse, waits for the core's valid, and returns a registered result with a
// one-cycle done pulse. The caller therefore never depends on core latency.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   req               request strobe, sampled only while idle
//   a, b              IEEE-754 double operands
//   op                0=LT 1=LEQ 2=GT 3=GEQ 4=EQ 5=NEQ (6/7 illegal)
//   busy              high from the cycle after accept until the cycle after done
//   done              one-cycle completion pulse
//   result            compare outcome, held until the next done
//   error             illegal op (or timeout), held with result
//   cmp_a/b/opcode/nd request side of the compare core
//   cmp_result/valid  response side of the compare core
//
// Optional feature: define SYNTHESIJER_FCOMP64_ISSUE_TIMEOUT_EN to abort a
// request after TIMEOUT_CYCLES cycles in WAIT. The abort returns result=0 and
// error=1. Without the macro, WAIT waits indefinitely.
// -----------------------------------------------------------------------------
module synthesijer_fcomp64_issue #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [2:0]  op,
  output logic        busy,
  output logic        done,
  output logic        result,
  output logic        error,
  output logic [63:0] cmp_a,
  output logic [63:0] cmp_b,
  output logic [7:0]  cmp_opcode,
  output logic        cmp_nd,
  input  logic        cmp_result,
  input  logic        cmp_valid
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 2..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] opcode_map;
  logic       illegal_op;
  logic       load_req;
  logic       capture;
  logic       abort;

`ifdef SYNTHESIJER_FCOMP64_ISSUE_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;
`endif

  // HLS comparison code -> compare-core operation byte (bits 7:6 always 0).
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    opcode_map = 8'h00;
    illegal_op = 1'b0;
    case (op)
      3'd0:    opcode_map = 8'h0C;  // LT
      3'd1:    opcode_map = 8'h1C;  // LEQ
      3'd2:    opcode_map = 8'h24;  // GT
      3'd3:    opcode_map = 8'h34;  // GEQ
      3'd4:    opcode_map = 8'h14;  // EQ
      3'd5:    opcode_map = 8'h2C;  // NEQ
      default: illegal_op = 1'b1;
    endcase
  end

  // Next-state logic. The ISSUE state never looks at cmp_valid: the core
  // cannot answer in the same cycle as nd, so anything seen there is stale.
  always_comb begin
    state_d  = state_q;
    load_req = 1'b0;
    capture  = 1'b0;
    abort    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          load_req = 1'b1;
          state_d  = illegal_op ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // A valid in the limit cycle takes priority over the timeout.
        if (cmp_valid) begin
          capture = 1'b1;
          state_d = S_DONE;
        end
`ifdef SYNTHESIJER_FCOMP64_ISSUE_TIMEOUT_EN
        else if (wait_cnt == TIMEOUT_LAST) begin
          abort   = 1'b1;
          state_d = S_DONE;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers. All outputs decode from state_d, so each one
  // lines up exactly with the state it describes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= 1'b0;
      error      <= 1'b0;
      cmp_a      <= '0;
      cmp_b      <= '0;
      cmp_opcode <= '0;
      cmp_nd     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      busy    <= (state_d != S_IDLE);
      done    <= (state_d == S_DONE);
      cmp_nd  <= (state_d == S_ISSUE);

      // Operands and opcode stay stable through ISSUE and WAIT.
      if (load_req) begin
        cmp_a      <= a;
        cmp_b      <= b;
        cmp_opcode <= opcode_map;
        if (illegal_op) begin
          result <= 1'b0;
          error  <= 1'b1;
        end
      end

      if (capture) begin
        result <= cmp_result;
        error  <= 1'b0;
      end

      if (abort) begin
        result <= 1'b0;
        error  <= 1'b1;
      end
    end
  end

`ifdef SYNTHESIJER_FCOMP64_ISSUE_TIMEOUT_EN
  // Counts WAIT cycles. It is cleared on the edge that enters WAIT and
  // advances once per cycle spent in WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state_q != S_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_synthesijer_fcomp64_issue.sv
// -----------------------------------------------------------------------------
// tb_synthesijer_fcomp64_issue
//
// Directed bench for synthesijer_fcomp64_issue. It includes a small compare-core
// model with a fixed 4-cycle latency. Cycle numbering for a request: the cycle
// with req high is cycle 1, so a legal request finishes with done in cycle 7,
// and an illegal op finishes with done in cycle 2. Outputs are sampled and
// inputs driven on the falling edge.
// -----------------------------------------------------------------------------
module tb_synthesijer_fcomp64_issue;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [2:0]  op = '0;
  logic        busy, done, result, error, cmp_nd;
  logic [63:0] cmp_a, cmp_b;
  logic [7:0]  cmp_opcode;
  logic        cmp_result, cmp_valid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  synthesijer_fcomp64_issue #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .a          (a),
    .b          (b),
    .op         (op),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .error      (error),
    .cmp_a      (cmp_a),
    .cmp_b      (cmp_b),
    .cmp_opcode (cmp_opcode),
    .cmp_nd     (cmp_nd),
    .cmp_result (cmp_result),
    .cmp_valid  (cmp_valid)
  );

  // Compare-core model. It decodes the operation byte, and valid follows nd
  // four cycles later. It has no reset, so a request aborted by reset still
  // produces a late valid.
  logic       core_en = 1'b1;
  logic       force_valid = 1'b0;
  logic       force_res = 1'b0;
  logic [3:0] vpipe = '0;
  logic [3:0] rpipe = '0;

  function automatic logic core_eval(input logic [63:0] x, input logic [63:0] y,
                                     input logic [7:0] opc);
    real rx, ry;
    rx = $bitstoreal(x);
    ry = $bitstoreal(y);
    case (opc)
      8'h0C:   return (rx <  ry);
      8'h1C:   return (rx <= ry);
      8'h24:   return (rx >  ry);
      8'h34:   return (rx >= ry);
      8'h14:   return (rx == ry);
      8'h2C:   return (rx != ry);
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    vpipe <= {vpipe[2:0], cmp_nd & core_en};
    rpipe <= {rpipe[2:0], core_eval(cmp_a, cmp_b, cmp_opcode)};
  end

  assign cmp_valid  = vpipe[3] | force_valid;
  assign cmp_result = vpipe[3] ? rpipe[3] : force_res;

  localparam logic [63:0] D_N1   = 64'hBFF0000000000000;  // -1.0
  localparam logic [63:0] D_N2   = 64'hC000000000000000;  // -2.0
  localparam logic [63:0] D_NH   = 64'hBFE0000000000000;  // -0.5
  localparam logic [63:0] D_1    = 64'h3FF0000000000000;  //  1.0
  localparam logic [63:0] D_15   = 64'h3FF8000000000000;  //  1.5
  localparam logic [63:0] D_2    = 64'h4000000000000000;  //  2.0
  localparam logic [63:0] D_3    = 64'h4008000000000000;  //  3.0
  localparam logic [63:0] D_QNAN = 64'h7FF8000000000000;

  // Issue one request, beginning in the current cycle (cycle 1). The task
  // returns on the falling edge of the cycle where done is seen.
  // force_at > 0 drives an extra cmp_valid (value fres) in that cycle.
  task automatic run_req(input string name, input logic [63:0] ta,
                         input logic [63:0] tb_v, input logic [2:0] top,
                         input int budget, input int force_at, input logic fres,
                         output int done_at, output int nd_cnt,
                         output logic [7:0] opc_seen);
    int cyc;
    a        = ta;
    b        = tb_v;
    op       = top;
    req      = 1'b1;
    cyc      = 1;
    done_at  = -1;
    nd_cnt   = 0;
    opc_seen = 8'h00;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      req         = 1'b0;
      force_valid = (cyc == force_at);
      force_res   = fres;
      if (cmp_nd) begin
        nd_cnt++;
        opc_seen = cmp_opcode;
      end
      if (done) begin
        done_at = cyc;
        break;
      end
    end
    force_valid = 1'b0;
    if (done_at < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, result, error, cmp_nd} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00000", {busy, done, result, error, cmp_nd});
    end
    n_cmp++;
    if ({cmp_a, cmp_b, cmp_opcode} !== 136'h0) begin
      n_bad++;
      $display("FAIL reset_cmp_bus: got a=%h b=%h opc=%h want zeros", cmp_a, cmp_b, cmp_opcode);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_spurious_idle();
    force_valid = 1'b1;
    force_res   = 1'b1;
    @(negedge clk);
    force_valid = 1'b0;
    force_res   = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({result, done, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL idle_valid: got result/done/busy=%b want 000", {result, done, busy});
    end
  endtask

  task automatic test_basic_lt();
    int d, n;
    logic [7:0] o;
    run_req("basic_lt", D_1, D_2, 3'd0, 30, 0, 1'b0, d, n, o);
    n_cmp++;
    if (d !== 7) begin n_bad++; $display("FAIL basic_latency: got %0d want 7", d); end
    n_cmp++;
    if (n !== 1) begin n_bad++; $display("FAIL basic_nd_pulses: got %0d want 1", n); end
    n_cmp++;
    if (o !== 8'h0C) begin n_bad++; $display("FAIL basic_opcode: got %h want 0c", o); end
    n_cmp++;
    if ({result, error} !== 2'b10) begin
      n_bad++;
      $display("FAIL basic_result: got result/error=%b want 10", {result, error});
    end
    n_cmp++;
    if ({cmp_a, cmp_b} !== {D_1, D_2}) begin
      n_bad++;
      $display("FAIL basic_operands: got a=%h b=%h want %h %h", cmp_a, cmp_b, D_1, D_2);
    end
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_in_done: got %b want 1", busy); end
    @(negedge clk);
    n_cmp++;
    if ({busy, done, result} !== 3'b001) begin
      n_bad++;
      $display("FAIL basic_after_done: got busy/done/result=%b want 001", {busy, done, result});
    end
  endtask

  task automatic test_opcode_map();
    logic [63:0] va [8];
    logic [63:0] vb [8];
    logic [2:0]  vo [8];
    logic [7:0]  vc [8];
    logic        vr [8];
    int d, n;
    logic [7:0] o;
    va = '{D_3,  D_2,  D_NH, D_1,  D_2,  D_2,  D_QNAN, D_QNAN};
    vb = '{D_N1, D_2,  D_N2, D_15, D_2,  D_2,  D_1,    D_1};
    vo = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0,   3'd5};
    vc = '{8'h0C, 8'h1C, 8'h24, 8'h34, 8'h14, 8'h2C, 8'h0C, 8'h2C};
    vr = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      run_req("opmap", va[i], vb[i], vo[i], 30, 0, 1'b0, d, n, o);
      n_cmp++;
      if (o !== vc[i]) begin n_bad++; $display("FAIL opmap_opcode[%0d]: got %h want %h", i, o, vc[i]); end
      n_cmp++;
      if (n !== 1) begin n_bad++; $display("FAIL opmap_nd[%0d]: got %0d want 1", i, n); end
      n_cmp++;
      if ({result, error} !== {vr[i], 1'b0}) begin
        n_bad++;
        $display("FAIL opmap_result[%0d]: got result/error=%b want %b0", i, {result, error}, vr[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    int n_done, n_nd, first;
    logic r_at, e_at;
    n_done = 0; n_nd = 0; first = -1; r_at = 1'bx; e_at = 1'bx;
    a = D_1; b = D_2; op = 3'd7; req = 1'b1;      // cycle 1
    for (int cyc = 2; cyc <= 12; cyc++) begin
      @(negedge clk);
      req = (cyc == 2);                           // held through the DONE cycle
      if (cmp_nd) n_nd++;
      if (done) begin
        n_done++;
        if (first < 0) begin first = cyc; r_at = result; e_at = error; end
      end
    end
    req = 1'b0;
    n_cmp++;
    if (first !== 2) begin n_bad++; $display("FAIL illegal_latency: got %0d want 2", first); end
    n_cmp++;
    if (n_done !== 1) begin n_bad++; $display("FAIL illegal_done_count: got %0d want 1", n_done); end
    n_cmp++;
    if (n_nd !== 0) begin n_bad++; $display("FAIL illegal_nd: got %0d pulses want 0", n_nd); end
    n_cmp++;
    if ({r_at, e_at} !== 2'b01) begin
      n_bad++;
      $display("FAIL illegal_result: got result/error=%b want 01", {r_at, e_at});
    end
    begin
      int d, n;
      logic [7:0] o;
      run_req("illegal6", D_2, D_1, 3'd6, 10, 0, 1'b0, d, n, o);
      n_cmp++;
      if ({d == 2, n == 0, result, error} !== 4'b1101) begin
        n_bad++;
        $display("FAIL illegal6: got done_at=%0d nd=%0d result/error=%b%b want 2 0 01", d, n, result, error);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_in_wait();
    int n_done, n_nd;
    n_done = 0; n_nd = 0;
    a = D_1; b = D_2; op = 3'd0; req = 1'b1;      // cycle 1
    @(negedge clk); req = 1'b0;                    // cycle 2: ISSUE
    @(negedge clk); reset = 1'b1;                  // cycle 3: WAIT
    @(negedge clk); reset = 1'b0;                  // cycle 4: IDLE after reset
    for (int i = 0; i < 10; i++) begin             // core answers in cycle 6
      @(negedge clk);
      if (done) n_done++;
      if (cmp_nd) n_nd++;
    end
    n_cmp++;
    if (n_done !== 0) begin n_bad++; $display("FAIL rst_wait_done: got %0d want 0", n_done); end
    n_cmp++;
    if (n_nd !== 0) begin n_bad++; $display("FAIL rst_wait_nd: got %0d want 0", n_nd); end
    n_cmp++;
    if ({busy, result, error} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_wait_state: got busy/result/error=%b want 000", {busy, result, error});
    end
  endtask

  task automatic test_wait_bound();
    int d, n, n_done;
    logic [7:0] o;
    core_en = 1'b0;
`ifdef SYNTHESIJER_FCOMP64_ISSUE_TIMEOUT_EN
    // WAIT is cycles 3..10, so the abort leads to done in cycle 11.
    run_req("timeout", D_1, D_2, 3'd0, 40, 0, 1'b0, d, n, o);
    n_cmp++;
    if (d !== 11) begin n_bad++; $display("FAIL timeout_latency: got %0d want 11", d); end
    n_cmp++;
    if ({result, error} !== 2'b01) begin
      n_bad++;
      $display("FAIL timeout_result: got result/error=%b want 01", {result, error});
    end
    n_done = 0;
    force_valid = 1'b1; force_res = 1'b1;
    @(negedge clk);
    force_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    n_cmp++;
    if ({n_done == 0, busy, result} !== 3'b100) begin
      n_bad++;
      $display("FAIL timeout_late_valid: got dones=%0d busy=%b result=%b want 0 0 0", n_done, busy, result);
    end
    // A valid in the last WAIT cycle (cycle 10) beats the timeout.
    run_req("timeout_tie", D_1, D_2, 3'd0, 40, 10, 1'b1, d, n, o);
    n_cmp++;
    if ({d == 11, result, error} !== 3'b110) begin
      n_bad++;
      $display("FAIL timeout_tie: got done_at=%0d result/error=%b%b want 11 10", d, result, error);
    end
`else
    // With no abort path, WAIT outlasts 64 cycles and finishes on valid.
    run_req("no_timeout", D_1, D_2, 3'd0, 90, 80, 1'b1, d, n, o);
    n_cmp++;
    if (d !== 81) begin n_bad++; $display("FAIL no_timeout_latency: got %0d want 81", d); end
    n_cmp++;
    if ({result, error} !== 2'b10) begin
      n_bad++;
      $display("FAIL no_timeout_result: got result/error=%b want 10", {result, error});
    end
    n_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    n_cmp++;
    if (n_done !== 0) begin n_bad++; $display("FAIL no_timeout_extra_done: got %0d want 0", n_done); end
`endif
    @(negedge clk);
    core_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int d, n;
    logic [7:0] o;
    run_req("b2b_first", D_2, D_1, 3'd3, 30, 0, 1'b0, d, n, o);
    n_cmp++;
    if ({d == 7, n == 1, o == 8'h34, result, error} !== 5'b11110) begin
      n_bad++;
      $display("FAIL b2b_first: got done_at=%0d nd=%0d opc=%h result/error=%b%b want 7 1 34 10",
               d, n, o, result, error);
    end
    @(negedge clk);                                // first cycle with busy low
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_drop: got %b want 0", busy); end
    run_req("b2b_second", D_2, D_1, 3'd0, 30, 0, 1'b0, d, n, o);
    n_cmp++;
    if (d !== 7) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want 7", d); end
    n_cmp++;
    if ({n == 1, o == 8'h0C} !== 2'b11) begin
      n_bad++;
      $display("FAIL b2b_second_issue: got nd=%0d opc=%h want 1 0c", n, o);
    end
    n_cmp++;
    if ({result, error} !== 2'b00) begin
      n_bad++;
      $display("FAIL b2b_second_result: got result/error=%b want 00", {result, error});
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_spurious_idle();
    test_basic_lt();
    test_opcode_map();
    test_illegal();
    test_reset_in_wait();
    test_wait_bound();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
